// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM state encoding and the pipe-control output bundle.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MDU_BUSY  = 2'd1,
      DMEM_WAIT = 2'd2,
      REPLAY    = 2'd3
   } hz_state_e;

   typedef struct packed {
      logic pc_hold;
      logic pc_redirect;
      logic if_id_hold;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_hold;
      logic ex_mem_bubble;
      logic mem_wb_bubble;
      logic mdu_hold;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_IDLE = '0;

   // Whole-pipe freeze while the data memory is busy.
   function automatic pipe_ctrl_t ctrl_freeze(input logic keep_mdu);
      pipe_ctrl_t c;
      c               = CTRL_IDLE;
      c.pc_hold       = 1'b1;
      c.if_id_hold    = 1'b1;
      c.id_ex_bubble  = 1'b1;
      c.ex_mem_hold   = 1'b1;
      c.mem_wb_bubble = 1'b1;
      c.mdu_hold      = keep_mdu;
      return c;
   endfunction

   // Front-end stall; MDU waits also bubble EX/MEM.
   function automatic pipe_ctrl_t ctrl_stall(input logic mdu_op);
      pipe_ctrl_t c;
      c               = CTRL_IDLE;
      c.pc_hold       = 1'b1;
      c.if_id_hold    = 1'b1;
      c.id_ex_bubble  = 1'b1;
      c.ex_mem_bubble = mdu_op;
      return c;
   endfunction

   function automatic pipe_ctrl_t ctrl_redirect();
      pipe_ctrl_t c;
      c              = CTRL_IDLE;
      c.pc_redirect  = 1'b1;
      c.if_id_flush  = 1'b1;
      c.id_ex_bubble = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose rd feeds
// a source operand of the instruction in ID.
module hazard_detect #(
   parameter int REG_COUNT = 32
) (
   input  logic                         ex_valid,
   input  logic                         ex_mem_read,
   input  logic [$clog2(REG_COUNT)-1:0] ex_rd_addr,
   input  logic [$clog2(REG_COUNT)-1:0] id_rs1_addr,
   input  logic [$clog2(REG_COUNT)-1:0] id_rs2_addr,
   input  logic                         id_uses_rs1,
   input  logic                         id_uses_rs2,
   output logic                         load_use
);

   logic rd_live;
   logic hit_rs1;
   logic hit_rs2;

   assign rd_live  = ex_valid && ex_mem_read && (ex_rd_addr != '0);
   assign hit_rs1  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
   assign hit_rs2  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
   assign load_use = rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: load-use stalls, branch flushes,
// MDU waits and dmem freezes with EX-instruction replay.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_WIDTH  = 64,
   parameter int REG_COUNT = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ex_valid,
   input  logic [PC_WIDTH-1:0]          ex_pc,
   input  logic                         ex_mem_read,
   input  logic [$clog2(REG_COUNT)-1:0] ex_rd_addr,
   input  logic [$clog2(REG_COUNT)-1:0] id_rs1_addr,
   input  logic [$clog2(REG_COUNT)-1:0] id_rs2_addr,
   input  logic                         id_uses_rs1,
   input  logic                         id_uses_rs2,
   input  logic                         ex_branch_taken,
   input  logic [PC_WIDTH-1:0]          ex_branch_target,
   input  logic                         ex_mdu_start,
   input  logic                         mdu_done,
   input  logic                         dmem_wait,
   output logic                         pc_hold,
   output logic                         pc_redirect,
   output logic [PC_WIDTH-1:0]          pc_redirect_target,
   output logic                         if_id_hold,
   output logic                         if_id_flush,
   output logic                         id_ex_bubble,
   output logic                         ex_mem_hold,
   output logic                         ex_mem_bubble,
   output logic                         mem_wb_bubble,
   output logic                         mdu_hold,
   output logic [CNT_WIDTH-1:0]         stall_cnt,
   output logic [CNT_WIDTH-1:0]         flush_cnt
);

   hz_state_e           state, state_nxt;
   logic [PC_WIDTH-1:0] replay_pc, replay_pc_nxt;
   logic                replay_pend, replay_pend_nxt;
   logic                mdu_pend, mdu_pend_nxt;
   pipe_ctrl_t          ctrl;
   logic [PC_WIDTH-1:0] target;
   logic                load_use;

   hazard_detect #(
      .REG_COUNT (REG_COUNT)
   ) u_detect (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd_addr  (ex_rd_addr),
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .load_use    (load_use)
   );

   // Per-state priority: dmem_wait > MDU > branch > load-use.
   always_comb begin
      ctrl            = CTRL_IDLE;
      target          = '0;
      state_nxt       = state;
      replay_pc_nxt   = replay_pc;
      replay_pend_nxt = replay_pend;
      mdu_pend_nxt    = mdu_pend;
      unique case (state)
         RUN: begin
            if (dmem_wait) begin
               ctrl            = ctrl_freeze(1'b0);
               replay_pc_nxt   = ex_pc;
               replay_pend_nxt = ex_valid;
               state_nxt       = DMEM_WAIT;
            end else if (ex_mdu_start && !mdu_done) begin
               ctrl      = ctrl_stall(1'b1);
               state_nxt = MDU_BUSY;
            end else if (ex_branch_taken) begin
               ctrl   = ctrl_redirect();
               target = ex_branch_target;
            end else if (load_use) begin
               ctrl = ctrl_stall(1'b0);
            end
         end
         MDU_BUSY: begin
            if (dmem_wait) begin
               ctrl            = ctrl_freeze(1'b1);
               mdu_pend_nxt    = 1'b1;
               replay_pend_nxt = 1'b0;
               state_nxt       = DMEM_WAIT;
            end else if (!mdu_done) begin
               ctrl = ctrl_stall(1'b1);
            end else begin
               state_nxt = RUN;
            end
         end
         DMEM_WAIT: begin
            if (dmem_wait) begin
               ctrl = ctrl_freeze(mdu_pend);
            end else if (mdu_pend) begin
               mdu_pend_nxt = 1'b0;
               state_nxt    = MDU_BUSY;
            end else if (replay_pend) begin
               state_nxt = REPLAY;
            end else begin
               state_nxt = RUN;
            end
         end
         REPLAY: begin
            replay_pend_nxt = 1'b0;
            if (dmem_wait) begin
               ctrl      = ctrl_freeze(1'b0);
               state_nxt = DMEM_WAIT;
            end else begin
               ctrl      = ctrl_redirect();
               target    = replay_pc;
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // FSM and replay bookkeeping registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RUN;
         replay_pc   <= '0;
         replay_pend <= 1'b0;
         mdu_pend    <= 1'b0;
      end else begin
         state       <= state_nxt;
         replay_pc   <= replay_pc_nxt;
         replay_pend <= replay_pend_nxt;
         mdu_pend    <= mdu_pend_nxt;
      end
   end

   // Wrapping stall / flush event counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, ctrl.pc_hold};
         flush_cnt <= flush_cnt + {{(CNT_WIDTH-1){1'b0}}, ctrl.if_id_flush};
      end
   end

   assign pc_hold            = ctrl.pc_hold;
   assign pc_redirect        = ctrl.pc_redirect;
   assign pc_redirect_target = target;
   assign if_id_hold         = ctrl.if_id_hold;
   assign if_id_flush        = ctrl.if_id_flush;
   assign id_ex_bubble       = ctrl.id_ex_bubble;
   assign ex_mem_hold        = ctrl.ex_mem_hold;
   assign ex_mem_bubble      = ctrl.ex_mem_bubble;
   assign mem_wb_bubble      = ctrl.mem_wb_bubble;
   assign mdu_hold           = ctrl.mdu_hold;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus a random run against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int PW = 64;
   localparam int RC = 32;
   localparam int CW = 6;
   localparam int AW = $clog2(RC);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ex_valid = 1'b0;
   logic [PW-1:0] ex_pc = '0;
   logic          ex_mem_read = 1'b0;
   logic [AW-1:0] ex_rd_addr = '0;
   logic [AW-1:0] id_rs1_addr = '0;
   logic [AW-1:0] id_rs2_addr = '0;
   logic          id_uses_rs1 = 1'b0;
   logic          id_uses_rs2 = 1'b0;
   logic          ex_branch_taken = 1'b0;
   logic [PW-1:0] ex_branch_target = '0;
   logic          ex_mdu_start = 1'b0;
   logic          mdu_done = 1'b0;
   logic          dmem_wait = 1'b0;

   logic          pc_hold, pc_redirect, if_id_hold, if_id_flush;
   logic          id_ex_bubble, ex_mem_hold, ex_mem_bubble;
   logic          mem_wb_bubble, mdu_hold;
   logic [PW-1:0] pc_redirect_target;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [8:0]    outs;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .PC_WIDTH (PW), .REG_COUNT (RC), .CNT_WIDTH (CW)
   ) dut (
      .clk (clk), .rst (rst),
      .ex_valid (ex_valid), .ex_pc (ex_pc),
      .ex_mem_read (ex_mem_read), .ex_rd_addr (ex_rd_addr),
      .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr),
      .id_uses_rs1 (id_uses_rs1), .id_uses_rs2 (id_uses_rs2),
      .ex_branch_taken (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
      .ex_mdu_start (ex_mdu_start), .mdu_done (mdu_done),
      .dmem_wait (dmem_wait),
      .pc_hold (pc_hold), .pc_redirect (pc_redirect),
      .pc_redirect_target (pc_redirect_target),
      .if_id_hold (if_id_hold), .if_id_flush (if_id_flush),
      .id_ex_bubble (id_ex_bubble), .ex_mem_hold (ex_mem_hold),
      .ex_mem_bubble (ex_mem_bubble), .mem_wb_bubble (mem_wb_bubble),
      .mdu_hold (mdu_hold),
      .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
   );

   assign outs = {pc_hold, pc_redirect, if_id_hold, if_id_flush,
                  id_ex_bubble, ex_mem_hold, ex_mem_bubble,
                  mem_wb_bubble, mdu_hold};

   // ---------------- behavioural model ----------------
   // Pipeline situation: memory frozen, MDU outstanding, MDU
   // parked behind a memory freeze, replay owed, and the PCs
   // still waiting to be replayed.
   bit            m_live = 0;
   bit            m_frozen, m_mdu, m_parked, m_replay_due;
   logic [PW-1:0] replay_q[$];
   logic [CW-1:0] m_stall, m_flush;

   always @(negedge clk) begin
      bit            frz, mstall, lu, redir, keep;
      logic [PW-1:0] tgt;
      logic [8:0]    exp_o;
      logic [PW-1:0] exp_t;
      if (!rst) begin
         m_live = 1; m_frozen = 0; m_mdu = 0; m_parked = 0;
         m_replay_due = 0; replay_q.delete();
         m_stall = '0; m_flush = '0;
      end else if (m_live) begin
         frz = 0; mstall = 0; lu = 0; redir = 0; keep = 0; tgt = '0;
         if (m_frozen) begin
            if (dmem_wait) begin
               frz = 1; keep = m_parked;
            end else begin
               m_frozen = 0;
               if (m_parked) begin
                  m_parked = 0; m_mdu = 1;
               end else if (replay_q.size() > 0) begin
                  m_replay_due = 1;
               end
            end
         end else if (dmem_wait) begin
            frz = 1; keep = m_mdu;
            replay_q.delete();
            if (!m_mdu && !m_replay_due && ex_valid)
               replay_q.push_back(ex_pc);
            m_parked = m_mdu; m_mdu = 0;
            m_replay_due = 0; m_frozen = 1;
         end else if (m_replay_due) begin
            redir = 1; tgt = replay_q.pop_front();
            m_replay_due = 0;
         end else if (m_mdu) begin
            if (mdu_done) m_mdu = 0;
            else mstall = 1;
         end else if (ex_mdu_start && !mdu_done) begin
            mstall = 1; m_mdu = 1;
         end else if (ex_branch_taken) begin
            redir = 1; tgt = ex_branch_target;
         end else begin
            lu = ex_valid && ex_mem_read && (ex_rd_addr != 0) &&
                 ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                  (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
         end
         exp_o = {frz | mstall | lu, redir, frz | mstall | lu, redir,
                  frz | mstall | lu | redir, frz, mstall, frz, keep};
         exp_t = tgt;
         n_vec++;
         if (outs !== exp_o) begin
            n_bad++;
            $display("FAIL model_ctrl t=%0t got %b want %b",
                     $time, outs, exp_o);
         end
         n_vec++;
         if (pc_redirect_target !== exp_t) begin
            n_bad++;
            $display("FAIL model_target t=%0t got %0h want %0h",
                     $time, pc_redirect_target, exp_t);
         end
         n_vec++;
         if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
            n_bad++;
            $display("FAIL model_cnt t=%0t got %0d/%0d want %0d/%0d",
                     $time, stall_cnt, flush_cnt, m_stall, m_flush);
         end
         m_stall = m_stall + CW'(exp_o[8]);
         m_flush = m_flush + CW'(redir);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid = 0; ex_pc = '0; ex_mem_read = 0; ex_rd_addr = '0;
      id_rs1_addr = '0; id_rs2_addr = '0;
      id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_branch_taken = 0; ex_branch_target = '0;
      ex_mdu_start = 0; mdu_done = 0; dmem_wait = 0;
   endtask

   task automatic do_reset();
      tick(); idle(); rst = 0;
      tick(); tick(); rst = 1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   initial begin
      idle();
      // reset state
      do_reset(); #2;
      chk("rst_outs", 64'(outs), 0);
      chk("rst_target", pc_redirect_target, 0);
      chk("rst_cnts", {stall_cnt, flush_cnt}, 0);

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      tick();
      ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 5;
      id_rs1_addr = 5; id_rs2_addr = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
      #2 chk("lu_stall", {pc_hold, if_id_hold, id_ex_bubble,
                          ex_mem_bubble}, 4'b1110);
      tick(); ex_valid = 0;
      #2 chk("lu_release", {pc_hold, if_id_hold, id_ex_bubble}, 0);
      chk("lu_cnt", stall_cnt, 1);
      tick(); ex_valid = 1; ex_rd_addr = 0; id_rs1_addr = 0;
      #2 chk("lu_x0", {pc_hold, id_ex_bubble}, 0);

      // branch beats load-use
      tick(); ex_rd_addr = 5; id_rs1_addr = 5;
      ex_branch_taken = 1; ex_branch_target = 64'h1000;
      #2 chk("br_ctrl", {pc_redirect, if_id_flush, id_ex_bubble,
                         pc_hold, if_id_hold}, 5'b11100);
      chk("br_target", pc_redirect_target, 64'h1000);
      tick(); idle();
      #2 chk("br_cnt", {stall_cnt, flush_cnt}, {6'd1, 6'd1});

      // MDU: 5 stall cycles, release on done
      do_reset(); ex_mdu_start = 1;
      #2 chk("mdu_s0", {pc_hold, ex_mem_bubble, ex_mem_hold}, 3'b110);
      for (int i = 1; i < 5; i++) begin
         tick(); idle();
         #2 chk("mdu_wait", {pc_hold, if_id_hold, ex_mem_bubble}, 3'b111);
      end
      tick(); mdu_done = 1;
      #2 chk("mdu_rel", 64'(outs), 0);
      chk("mdu_cnt", stall_cnt, 5);
      tick(); ex_mdu_start = 1; mdu_done = 1;
      #2 chk("mdu_1cyc", {pc_hold, ex_mem_bubble}, 0);
      tick(); idle();
      #2 chk("mdu_1cyc_cnt", stall_cnt, 5);

      // DMEM freeze with replay of EX instruction
      do_reset(); ex_valid = 1; ex_pc = 64'h200; dmem_wait = 1;
      #2 chk("dm_frz0", {pc_hold, if_id_hold, id_ex_bubble, ex_mem_hold,
                         mem_wb_bubble, mdu_hold}, 6'b111110);
      for (int i = 1; i < 3; i++) begin
         tick(); ex_pc = 64'h300;
         #2 chk("dm_frz", {pc_hold, ex_mem_hold, mem_wb_bubble}, 3'b111);
      end
      tick(); dmem_wait = 0; ex_valid = 0;
      #2 chk("dm_done", 64'(outs), 0);
      tick();
      #2 chk("dm_replay", {pc_redirect, if_id_flush, id_ex_bubble,
                           pc_hold}, 4'b1110);
      chk("dm_rtarget", pc_redirect_target, 64'h200);
      tick();
      #2 chk("dm_after", 64'(outs), 0);
      chk("dm_cnt", {stall_cnt, flush_cnt}, {6'd3, 6'd1});

      // DMEM freeze with bubble in EX: no replay
      do_reset(); dmem_wait = 1;
      tick(); tick();
      tick(); dmem_wait = 0;
      tick();
      #2 chk("dm_norep", {pc_redirect, if_id_flush}, 0);

      // dmem_wait during MDU_BUSY
      do_reset(); ex_mdu_start = 1;
      tick(); ex_mdu_start = 0; dmem_wait = 1;
      #2 chk("mm_frz", {mdu_hold, pc_hold, ex_mem_hold, ex_mem_bubble},
             4'b1110);
      tick(); mdu_done = 1;
      #2 chk("mm_hold", {mdu_hold, mem_wb_bubble}, 2'b11);
      tick(); dmem_wait = 0;
      #2 chk("mm_exit", 64'(outs), 0);
      tick(); mdu_done = 0;
      #2 chk("mm_busy", {pc_hold, ex_mem_bubble, mdu_hold}, 3'b110);
      tick(); mdu_done = 1;
      #2 chk("mm_rel", 64'(outs), 0);
      tick(); mdu_done = 0;
      #2 chk("mm_norep", 64'(outs), 0);
      chk("mm_cnt", {stall_cnt, flush_cnt}, {6'd4, 6'd0});

      // reset mid-freeze abandons replay
      do_reset(); ex_valid = 1; ex_pc = 64'h400; dmem_wait = 1;
      tick();
      tick(); rst = 0; idle();
      tick(); rst = 1;
      #2 chk("rf_outs", 64'(outs), 0);
      chk("rf_cnts", {stall_cnt, flush_cnt}, 0);
      tick();
      #2 chk("rf_norep", {pc_redirect, if_id_flush}, 0);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst = ($urandom_range(0, 299) != 0);
         ex_valid = ($urandom_range(0, 3) != 0);
         ex_pc = {$urandom, $urandom};
         ex_mem_read = $urandom_range(0, 1);
         ex_rd_addr = AW'($urandom_range(0, 3));
         id_rs1_addr = AW'($urandom_range(0, 3));
         id_rs2_addr = AW'($urandom_range(0, 3));
         id_uses_rs1 = $urandom_range(0, 1);
         id_uses_rs2 = $urandom_range(0, 1);
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         ex_branch_target = {$urandom, $urandom};
         ex_mdu_start = ($urandom_range(0, 5) == 0);
         mdu_done = ($urandom_range(0, 3) == 0);
         dmem_wait = ($urandom_range(0, 5) == 0);
      end
      tick(); rst = 1; idle();
      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the five-stage pipeline.
- Sequences PC, IF/ID, ID/EX, EX/MEM and MEM/WB for four cases: load-use stalls, taken-branch flushes, multi-cycle MDU ops and data-memory wait states.
- The ID/EX register can only bubble (its stall and flush both zero it); it has no hold. The block therefore replays the EX-stage instruction after a memory freeze.
- Also keeps stall and flush event counters for performance debug.

Parameters:
- PC_WIDTH, 64, PC / branch target width
- REG_COUNT, 32, register file size; address width is clog2(REG_COUNT)
- CNT_WIDTH, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- ex_valid  in  1  EX slot holds a real instruction (not a bubble)
- ex_pc  in  PC_WIDTH  PC of the EX instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_rd_addr  in  clog2(REG_COUNT)  EX destination register
- id_rs1_addr, id_rs2_addr  in  clog2(REG_COUNT)  ID source registers
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2
- ex_branch_taken  in  1  EX branch/jump resolved taken
- ex_branch_target  in  PC_WIDTH  resolved target
- ex_mdu_start  in  1  EX issues a multi-cycle MDU op (MDU latches operands, rd and WB control)
- mdu_done  in  1  MDU result valid this cycle
- dmem_wait  in  1  MEM-stage access not complete
- pc_hold  out  1  PC keeps its value
- pc_redirect  out  1  PC loads pc_redirect_target
- pc_redirect_target  out  PC_WIDTH
- if_id_hold  out  1
- if_id_flush  out  1
- id_ex_bubble  out  1  drives ID/EX stall/flush
- ex_mem_hold  out  1
- ex_mem_bubble  out  1
- mem_wb_bubble  out  1
- mdu_hold  out  1  MDU must retain its done/result while high
- stall_cnt  out  CNT_WIDTH  cycles with pc_hold=1
- flush_cnt  out  CNT_WIDTH  cycles with if_id_flush=1

Behaviour:
- States: RUN, MDU_BUSY, DMEM_WAIT, REPLAY. Registers: state, replay_pc, replay_pend, mdu_pend, both counters.
- Reset (rst=0 at a clock edge) has priority over everything:
  - state=RUN, flags=0, counters=0.
  - All outputs are 0 while in RUN with idle inputs.
  - Reset mid-freeze abandons the replay.
- Outputs are combinational from state and inputs. Default for every output is 0.
- Priority in every state: dmem_wait > MDU > branch > load-use.
- RUN:
  - dmem_wait=1 → freeze: pc_hold, if_id_hold, ex_mem_hold, mem_wb_bubble, id_ex_bubble. Capture replay_pc=ex_pc and replay_pend=ex_valid. Next state DMEM_WAIT.
  - ex_mdu_start & !mdu_done → pc_hold, if_id_hold, id_ex_bubble, ex_mem_bubble. Next state MDU_BUSY.
  - ex_mdu_start & mdu_done (single-cycle) → no stall.
  - ex_branch_taken → pc_redirect with target=ex_branch_target, if_id_flush, id_ex_bubble.
  - Load-use: ex_valid & ex_mem_read & ex_rd_addr!=0 & ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd)) → pc_hold, if_id_hold, id_ex_bubble for exactly 1 cycle. Taken branch overrides load-use.
- MDU_BUSY:
  - While !mdu_done: pc_hold, if_id_hold, id_ex_bubble, ex_mem_bubble.
  - mdu_done → all outputs 0 (EX/MEM captures the MDU result); next state RUN.
  - dmem_wait → freeze outputs plus mdu_hold; set mdu_pend=1, replay_pend=0; next state DMEM_WAIT.
- DMEM_WAIT:
  - Freeze outputs held while dmem_wait=1; mdu_hold=mdu_pend.
  - On dmem_wait=0: the completing cycle gives all holds 0.
    - If mdu_pend: clear it, go to MDU_BUSY.
    - Else if replay_pend: go to REPLAY.
    - Else go to RUN.
- REPLAY (1 cycle): pc_redirect with target=replay_pc, if_id_flush, id_ex_bubble; next state RUN. dmem_wait here takes the DMEM_WAIT entry path with replay_pend=0.
- Counters: +1 per qualifying cycle, wrap modulo 2^CNT_WIDTH.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state enum (RUN=0, MDU_BUSY=1, DMEM_WAIT=2, REPLAY=3) and the pipe-control output bundle typedef.
- One sub-module, hazard_detect: the purely combinational load-use comparator.

Test Plan:
- Load-use: ex lw x5, id add x6,x5,x1 (uses_rs1=1) → pc_hold/if_id_hold/id_ex_bubble high 1 cycle, then 0. Repeat with rd=x0 → no stall.
- Branch beats load-use: branch_taken=1, target=0x1000, simultaneous load-use match → pc_redirect=1, target 0x1000, if_id_flush=1, pc_hold=0, flush_cnt=1.
- MDU: ex_mdu_start, mdu_done after 5 cycles → 5 stall cycles with ex_mem_bubble=1, release on the done cycle, stall_cnt=5; start with done in the same cycle → 0 stalls.
- DMEM: dmem_wait 3 cycles with ex_valid=1, ex_pc=0x200 → freeze 3 cycles, then REPLAY with redirect to 0x200; with ex_valid=0 → no REPLAY.
- dmem_wait during MDU_BUSY: mdu_done while frozen → mdu_hold=1; after the wait → MDU_BUSY, release on the done cycle, no replay.
- rst=0 mid-DMEM_WAIT → next cycle state RUN, counters 0, no redirect.
